issue_entry_buffer: RTL and testbench

Entry-storage and allocation stage that sits in front of `age_matrix` in an issue queue.
- Accepts up to `NumEnq` instructions per cycle and allocates them to free entries. Drives `age_matrix` enqueue, dequeue and select inputs.
- Holds payload plus a per-entry ready bit, and issues the entries named by `age_matrix` results on `NumSel` valid/ready ports.
- Deallocates issued entries and supports a full flush.

---
 rtl/issue_entry_buffer.sv | 165 ++++++++++++++++
 tb/tb_issue_entry_buffer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_entry_buffer.sv
// issue_entry_buffer: entry storage and allocation in front of age_matrix.
// Allocates up to NumEnq new entries per cycle to the lowest free slots,
// tracks operand readiness, and issues and frees the entries that age_matrix picks.
module issue_entry_buffer #(
  parameter int unsigned NumEntries = 4,
  parameter int unsigned NumEnq     = 2,
  parameter int unsigned NumSel     = 2,
  parameter int unsigned DataWidth  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            flush_i,
  input  logic [NumEnq-1:0]               enq_valid_i,
  output logic [NumEnq-1:0]               enq_ready_o,
  input  logic [NumEnq*DataWidth-1:0]     enq_data_i,
  input  logic [NumEnq-1:0]               enq_rdy_i,
  input  logic [NumEntries-1:0]           wakeup_i,
  output logic [NumEnq-1:0]               enq_fire_o,
  output logic [NumEnq*NumEntries-1:0]    enq_mask_o,
  output logic [NumEntries-1:0]           entry_vld_o,
  output logic [NumEntries-1:0]           sel_mask_o,
  input  logic [NumSel*NumEntries-1:0]    result_mask_i,
  output logic                            deq_fire_o,
  output logic [NumEntries-1:0]           deq_mask_o,
  output logic [NumSel-1:0]               iss_valid_o,
  input  logic [NumSel-1:0]               iss_ready_i,
  output logic [NumSel*DataWidth-1:0]     iss_data_o,
  output logic [$clog2(NumEntries+1)-1:0] count_o
);

  localparam int unsigned CntW = $clog2(NumEntries + 1);

  logic [NumEntries-1:0] vld_q, vld_d;
  logic [NumEntries-1:0] rdy_q, rdy_d;
  logic [DataWidth-1:0]  data_q [NumEntries];
  logic [DataWidth-1:0]  data_d [NumEntries];

  logic                  active;
  logic [CntW-1:0]       nfree;
  logic [CntW-1:0]       nvld;
  logic [NumEntries-1:0] avail;
  logic                  found;
  logic [NumEntries-1:0] res_row [NumSel];
  logic [DataWidth-1:0]  iss_mux;

  // No handshakes may complete during reset or flush.
  assign active = rst_ni & ~flush_i;

  // Free-slot counting and in-order allocation of fired ports to the lowest free entries.
  always_comb begin
    nfree       = '0;
    nvld        = '0;
    avail       = ~vld_q;
    enq_ready_o = '0;
    enq_fire_o  = '0;
    enq_mask_o  = '0;
    found       = 1'b0;
    for (int unsigned e = 0; e < NumEntries; e++) begin
      nfree = nfree + CntW'(~vld_q[e]);
      nvld  = nvld + CntW'(vld_q[e]);
    end
    for (int unsigned k = 0; k < NumEnq; k++) begin
      enq_ready_o[k] = (nfree > CntW'(k)) & active;
      enq_fire_o[k]  = enq_valid_i[k] & enq_ready_o[k];
      found          = 1'b0;
      if (enq_fire_o[k]) begin
        // Each fired port consumes the lowest slot still available, so port k
        // lands on the r-th free entry where r counts earlier fired ports.
        for (int unsigned e = 0; e < NumEntries; e++) begin
          if (!found && avail[e]) begin
            enq_mask_o[k*NumEntries+e] = 1'b1;
            avail[e]                   = 1'b0;
            found                      = 1'b1;
          end
        end
      end
    end
  end

  // Issue ports: one-hot payload mux and dequeue of accepted picks.
  always_comb begin
    iss_valid_o = '0;
    iss_data_o  = '0;
    deq_mask_o  = '0;
    iss_mux     = '0;
    for (int unsigned i = 0; i < NumSel; i++) begin
      res_row[i]     = result_mask_i[i*NumEntries +: NumEntries];
      iss_valid_o[i] = (|res_row[i]) & active;
      iss_mux        = '0;
      for (int unsigned e = 0; e < NumEntries; e++) begin
        if (res_row[i][e]) iss_mux = iss_mux | data_q[e];
      end
      iss_data_o[i*DataWidth +: DataWidth] = rst_ni ? iss_mux : '0;
      if (iss_valid_o[i] && iss_ready_i[i]) deq_mask_o = deq_mask_o | res_row[i];
    end
    deq_fire_o = |deq_mask_o;
  end

  // Status outputs toward age_matrix and the pipeline.
  always_comb begin
    entry_vld_o = rst_ni ? vld_q : '0;
    sel_mask_o  = vld_q & rdy_q & {NumEntries{active}};
    count_o     = rst_ni ? nvld : '0;
  end

  // Next-state: wakeup, dequeue, enqueue writes, then flush overrides all.
  always_comb begin
    vld_d  = vld_q & ~deq_mask_o;
    rdy_d  = (rdy_q | (wakeup_i & vld_q)) & ~deq_mask_o;
    data_d = data_q;
    // Enqueued entries are currently invalid, so the wakeup term above cannot
    // touch them and the enqueue ready value wins outright.
    for (int unsigned k = 0; k < NumEnq; k++) begin
      for (int unsigned e = 0; e < NumEntries; e++) begin
        if (enq_mask_o[k*NumEntries+e]) begin
          vld_d[e]  = 1'b1;
          rdy_d[e]  = enq_rdy_i[k];
          data_d[e] = enq_data_i[k*DataWidth +: DataWidth];
        end
      end
    end
    if (flush_i) begin
      vld_d = '0;
      rdy_d = '0;
    end
  end

  // Valid/ready state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      rdy_q <= '0;
    end else begin
      vld_q <= vld_d;
      rdy_q <= rdy_d;
    end
  end

  // Payload storage; unreset since it is only observed through valid entries.
  always_ff @(posedge clk_i) begin
    data_q <= data_d;
  end

`ifndef SYNTHESIS
  // Protocol checks on the age_matrix picks and on the allocator.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i) begin
      for (int unsigned i = 0; i < NumSel; i++) begin
        assert ($onehot0(res_row[i]) && ((res_row[i] & ~sel_mask_o) == '0));
        for (int unsigned j = i + 1; j < NumSel; j++) begin
          assert ((res_row[i] & res_row[j]) == '0);
        end
      end
      for (int unsigned k = 0; k < NumEnq; k++) begin
        assert ((enq_mask_o[k*NumEntries +: NumEntries] & vld_q) == '0);
        for (int unsigned j = k + 1; j < NumEnq; j++) begin
          assert ((enq_mask_o[k*NumEntries +: NumEntries] &
                   enq_mask_o[j*NumEntries +: NumEntries]) == '0);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_issue_entry_buffer.sv
// Directed bench for issue_entry_buffer with a per-cycle behavioural model.
module tb_issue_entry_buffer;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [1:0]  enq_valid;
  logic [1:0]  enq_ready;
  logic [63:0] enq_data;
  logic [1:0]  enq_rdy;
  logic [3:0]  wakeup;
  logic [1:0]  enq_fire;
  logic [7:0]  enq_mask;
  logic [3:0]  entry_vld;
  logic [3:0]  sel_mask;
  logic [7:0]  result_mask;
  logic        deq_fire;
  logic [3:0]  deq_mask;
  logic [1:0]  iss_valid;
  logic [1:0]  iss_ready;
  logic [63:0] iss_data;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  issue_entry_buffer #(.NumEntries(4), .NumEnq(2), .NumSel(2), .DataWidth(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .enq_valid_i(enq_valid), .enq_ready_o(enq_ready), .enq_data_i(enq_data),
    .enq_rdy_i(enq_rdy), .wakeup_i(wakeup), .enq_fire_o(enq_fire),
    .enq_mask_o(enq_mask), .entry_vld_o(entry_vld), .sel_mask_o(sel_mask),
    .result_mask_i(result_mask), .deq_fire_o(deq_fire), .deq_mask_o(deq_mask),
    .iss_valid_o(iss_valid), .iss_ready_i(iss_ready), .iss_data_o(iss_data),
    .count_o(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: a plain list of slots with valid/ready/payload.
  bit          m_vld [4];
  bit          m_rdy [4];
  logic [31:0] m_data[4];
  bit          n_vld [4] = '{default: 0};
  bit          n_rdy [4] = '{default: 0};
  logic [31:0] n_data[4] = '{default: '0};

  always @(posedge clk) begin
    m_vld  <= n_vld;
    m_rdy  <= n_rdy;
    m_data <= n_data;
  end

  // Compare process: derive expected outputs from model state and inputs mid-cycle.
  always @(negedge clk) begin
    int unsigned fq[$];
    int unsigned e;
    logic [1:0]  x_ready, x_fire, x_ival;
    logic [7:0]  x_mask;
    logic [3:0]  x_vld, x_sel, x_deq, row;
    logic [63:0] x_idata;
    logic [2:0]  x_cnt;
    bit          act;
    fq.delete();
    x_ready = '0; x_fire = '0; x_ival = '0; x_mask = '0;
    x_vld = '0; x_sel = '0; x_deq = '0; x_idata = '0; x_cnt = '0;
    n_vld = m_vld; n_rdy = m_rdy; n_data = m_data;
    act = rst_n && !flush;
    if (rst_n) begin
      for (int s = 0; s < 4; s++) begin
        if (!m_vld[s]) fq.push_back(s);
        x_vld[s] = m_vld[s];
        x_sel[s] = m_vld[s] && m_rdy[s] && act;
        if (m_vld[s]) x_cnt++;
      end
      for (int k = 0; k < 2; k++) begin
        x_ready[k] = act && (fq.size() > k);
      end
      for (int i = 0; i < 2; i++) begin
        row = result_mask[i*4 +: 4];
        x_ival[i] = (row != 0) && act;
        for (int s = 0; s < 4; s++)
          if (row[s]) x_idata[i*32 +: 32] = x_idata[i*32 +: 32] | m_data[s];
        if (x_ival[i] && iss_ready[i]) x_deq = x_deq | row;
      end
      for (int s = 0; s < 4; s++)
        if (wakeup[s] && m_vld[s]) n_rdy[s] = 1;
      for (int s = 0; s < 4; s++)
        if (x_deq[s]) begin n_vld[s] = 0; n_rdy[s] = 0; end
      for (int k = 0; k < 2; k++) begin
        x_fire[k] = enq_valid[k] && x_ready[k];
        if (x_fire[k]) begin
          e = fq.pop_front();
          x_mask[k*4 + e] = 1'b1;
          n_vld[e] = 1; n_rdy[e] = enq_rdy[k]; n_data[e] = enq_data[k*32 +: 32];
        end
      end
    end
    if (!rst_n || flush) begin
      n_vld = '{default: 0};
      n_rdy = '{default: 0};
    end
    chk("enq_ready", enq_ready, x_ready);
    chk("enq_fire", enq_fire, x_fire);
    chk("enq_mask", enq_mask, x_mask);
    chk("entry_vld", entry_vld, x_vld);
    chk("sel_mask", sel_mask, x_sel);
    chk("iss_valid", iss_valid, x_ival);
    chk("iss_data", iss_data, x_idata);
    chk("deq_mask", deq_mask, x_deq);
    chk("deq_fire", deq_fire, x_deq != 0);
    chk("count", count, x_cnt);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] ev, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [1:0] er, input logic [3:0] wk, input logic [3:0] rm0,
                       input logic [3:0] rm1, input logic [1:0] ir, input logic fl);
    enq_valid = ev; enq_data = {d1, d0}; enq_rdy = er; wakeup = wk;
    result_mask = {rm1, rm0}; iss_ready = ir; flush = fl;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    tick();
    chk("lit_reset_enq_ready", enq_ready, 2'b00);
    chk("lit_reset_count", count, 3'd0);
    tick();
    rst_n = 1'b1;
    // Two-port enqueue into an empty queue.
    drive(2'b11, 32'hA, 32'hB, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t1_enq_mask", enq_mask, 8'b0010_0001);
    chk("lit_t1_enq_fire", enq_fire, 2'b11);
    tick();
    drive(2'b01, 32'hE, 0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t1_entry_vld", entry_vld, 4'b0011);
    chk("lit_t1_sel_mask", sel_mask, 4'b0011);
    chk("lit_t1_count", count, 3'd2);
    chk("lit_t2_ready2", enq_ready, 2'b11);
    tick();
    drive(2'b01, 32'hF, 0, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t2_ready1", enq_ready, 2'b01);
    chk("lit_t2_count3", count, 3'd3);
    chk("lit_t2_mask3", enq_mask, 8'b0000_1000);
    tick();
    drive(2'b11, 32'h1, 32'h2, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t2_ready0", enq_ready, 2'b00);
    chk("lit_t2_count4", count, 3'd4);
    chk("lit_t2_nofire", enq_fire, 2'b00);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b1);
    chk("lit_flush_ready", enq_ready, 2'b00);
    tick();
    // Gap on port 0: port 1 takes the lowest free entry.
    drive(2'b10, 0, 32'hC, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_flush_count", count, 3'd0);
    chk("lit_t3_enq_fire", enq_fire, 2'b10);
    chk("lit_t3_enq_mask", enq_mask, 8'b0001_0000);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'b0001, 4'h0, 2'b00, 1'b0);
    chk("lit_t3_entry_vld", entry_vld, 4'b0001);
    chk("lit_t3_data_c", iss_data[31:0], 32'hC);
    // Stalled issue keeps the entry, accepted issue frees it.
    drive(2'b11, 32'h11, 32'hD, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t4_enq_mask", enq_mask, 8'b0100_0010);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'b0100, 4'h0, 2'b00, 1'b0);
    chk("lit_t4_iss_valid", iss_valid, 2'b01);
    chk("lit_t4_iss_data", iss_data[31:0], 32'hD);
    chk("lit_t4_no_deq", deq_fire, 1'b0);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'b0100, 4'h0, 2'b01, 1'b0);
    chk("lit_t4_stays", entry_vld, 4'b0111);
    chk("lit_t4_deq_mask", deq_mask, 4'b0100);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'b0001, 4'b0010, 2'b11, 1'b0);
    chk("lit_t4_freed", entry_vld, 4'b0011);
    chk("lit_t5_dual_deq", deq_mask, 4'b0011);
    chk("lit_t5_data1", iss_data[63:32], 32'h11);
    tick();
    // Not-ready enqueue, wakeup, and ignored wakeups.
    drive(2'b01, 32'h55, 0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t5_enq_mask", enq_mask, 8'b0000_0001);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'b0011, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t5_not_sel", sel_mask, 4'b0000);
    tick();
    drive(2'b01, 32'h56, 0, 2'b00, 4'b0010, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t5_woken", sel_mask, 4'b0001);
    tick();
    drive(2'b01, 32'h66, 0, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t5_enq_wake_ignored", sel_mask, 4'b0001);
    chk("lit_t5_mask2", enq_mask, 8'b0000_0100);
    tick();
    // Flush beats enqueue and issue.
    drive(2'b11, 32'h7, 32'h8, 2'b11, 4'h0, 4'b0001, 4'b0100, 2'b11, 1'b1);
    chk("lit_t6_count3", count, 3'd3);
    chk("lit_t6_no_enq", enq_fire, 2'b00);
    chk("lit_t6_no_iss", iss_valid, 2'b00);
    chk("lit_t6_no_deq", deq_fire, 1'b0);
    tick();
    drive(2'b11, 32'h71, 32'h72, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_t6_vld", entry_vld, 4'b0000);
    chk("lit_t6_ready", enq_ready, 2'b11);
    tick();
    drive(2'b11, 32'h73, 32'h74, 2'b11, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    tick();
    // Slot freed this cycle is not yet allocatable.
    drive(2'b01, 32'h77, 0, 2'b01, 4'h0, 4'b0010, 4'h0, 2'b01, 1'b0);
    chk("lit_full_ready", enq_ready, 2'b00);
    chk("lit_full_deq", deq_mask, 4'b0010);
    tick();
    drive(2'b01, 32'h77, 0, 2'b01, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_realloc_mask", enq_mask, 8'b0000_0010);
    chk("lit_realloc_vld", entry_vld, 4'b1101);
    tick();
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'b0010, 4'h0, 2'b00, 1'b0);
    chk("lit_realloc_data", iss_data[31:0], 32'h77);
    tick();
    // Reset mid-operation: everything drops, no dequeue pulse.
    rst_n = 1'b0;
    drive(2'b01, 32'h99, 0, 2'b01, 4'h0, 4'b0010, 4'h0, 2'b01, 1'b0);
    chk("lit_rst_no_deq", deq_fire, 1'b0);
    chk("lit_rst_vld", entry_vld, 4'b0000);
    chk("lit_rst_ready", enq_ready, 2'b00);
    tick();
    rst_n = 1'b1;
    drive(2'b00, 0, 0, 2'b00, 4'h0, 4'h0, 4'h0, 2'b00, 1'b0);
    chk("lit_post_rst_count", count, 3'd0);
    chk("lit_post_rst_ready", enq_ready, 2'b11);
    tick();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
